// File: rtl/scan_loader_pkg.sv
// Shared definitions for the scan-chain program loader: state encoding and
// default geometry, kept in step with memory_bank's MEM_SIZE.
package scan_loader_pkg;

   localparam int SL_DATA_WIDTH  = 8;   // bits per memory cell / transferred byte
   localparam int SL_CHAIN_BYTES = 32;  // cells in the scan chain (memory_bank MEM_SIZE)
   localparam int SL_CNT_WIDTH   = 6;   // byte counter width, 2**SL_CNT_WIDTH > SL_CHAIN_BYTES

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/scan_loader.sv
// Serial program loader for memory_bank's scan chain. Each accepted byte is
// shifted MSB-first into the chain while the bit emerging from scan_out is
// captured into the same shift register, so a load also dumps the old image.
module scan_loader
   import scan_loader_pkg::*;
#(
   parameter int DATA_WIDTH  = SL_DATA_WIDTH,
   parameter int CHAIN_BYTES = SL_CHAIN_BYTES,
   parameter int CNT_WIDTH   = SL_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,          // asynchronous, active low
   input  logic                  start,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] byte_in,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   output logic                  scan_enable,
   output logic                  scan_in,
   input  logic                  scan_out_in,
   output logic [DATA_WIDTH-1:0] byte_out,
   output logic                  byte_out_valid,
   output logic                  busy,
   output logic                  done
);

   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_W-1:0]     LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] LAST_BYTE = CNT_WIDTH'(CHAIN_BYTES - 1);

   state_t                state_q;
   logic [DATA_WIDTH-1:0] shreg_q;
   logic [DATA_WIDTH-1:0] shreg_d;
   logic [BIT_W-1:0]      bit_cnt_q;
   logic [CNT_WIDTH-1:0]  byte_cnt_q;
   logic [DATA_WIDTH-1:0] byte_out_q;
   logic                  byte_out_valid_q;
   logic                  done_q;

   // Next shift-register value: outgoing MSB leaves, chain's scan_out enters at the LSB
   always_comb begin
      shreg_d = {shreg_q[DATA_WIDTH-2:0], scan_out_in};
   end

   // Control FSM with counters, shift register and registered pulse outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= ST_IDLE;
         shreg_q          <= '0;
         bit_cnt_q        <= '0;
         byte_cnt_q       <= '0;
         byte_out_q       <= '0;
         byte_out_valid_q <= 1'b0;
         done_q           <= 1'b0;
      end else begin
         byte_out_valid_q <= 1'b0;
         done_q           <= 1'b0;
         if (abort) begin
            // abort beats start, handshakes and the last-bit pulses alike
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     byte_cnt_q <= '0;
                     state_q    <= ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  if (byte_valid) begin
                     shreg_q   <= byte_in;
                     bit_cnt_q <= '0;
                     state_q   <= ST_SHIFT;
                  end
               end
               ST_SHIFT: begin
                  shreg_q <= shreg_d;
                  if (bit_cnt_q == LAST_BIT) begin
                     // the captured byte includes this edge's scan_out bit
                     bit_cnt_q        <= '0;
                     byte_out_q       <= shreg_d;
                     byte_out_valid_q <= 1'b1;
                     if (byte_cnt_q == LAST_BYTE) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                     end else begin
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        state_q    <= ST_LOAD;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
               ST_DONE: begin
                  state_q <= ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Chain-side strobes decode straight from the state register so an async reset drops them at once
   always_comb begin
      byte_ready  = (state_q == ST_LOAD);
      scan_enable = (state_q == ST_SHIFT);
      scan_in     = shreg_q[DATA_WIDTH-1];
      busy        = (state_q != ST_IDLE);
   end

   assign byte_out       = byte_out_q;
   assign byte_out_valid = byte_out_valid_q;
   assign done           = done_q;

endmodule

// File: tb/tb_scan_loader.sv
// Self-checking bench for scan_loader, driving a behavioural 32-byte scan chain.
`timescale 1ns/1ps
module tb_scan_loader;

   localparam int DW = 8;
   localparam int NB = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, abort, byte_valid;
   logic [DW-1:0] byte_in;
   logic          byte_ready, scan_enable, scan_in, scan_out;
   logic [DW-1:0] byte_out;
   logic          byte_out_valid, busy, done;

   always #5 clk = ~clk;

   // behavioural memory_bank chain: mem[k] = chain[8k+7:8k], scan_in enters address 0
   logic [NB*DW-1:0] chain;
   logic [NB*DW-1:0] preload_val;
   logic             preload_en;

   always @(posedge clk) begin
      if (preload_en)       chain <= preload_val;
      else if (scan_enable) chain <= {chain[NB*DW-2:0], scan_in};
   end
   assign scan_out = chain[NB*DW-1];

   scan_loader dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .abort          (abort),
      .byte_in        (byte_in),
      .byte_valid     (byte_valid),
      .byte_ready     (byte_ready),
      .scan_enable    (scan_enable),
      .scan_in        (scan_in),
      .scan_out_in    (scan_out),
      .byte_out       (byte_out),
      .byte_out_valid (byte_out_valid),
      .busy           (busy),
      .done           (done)
   );

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] load_data [NB];
   logic [DW-1:0] rb_q [$];
   int            ld_done_cyc;
   int            ld_se_cnt;

   typedef struct packed {
      logic          start;
      logic          abort;
      logic          bv;
      logic [DW-1:0] din;
      logic [5:0]    exp;   // {busy, byte_ready, scan_enable, scan_in, byte_out_valid, done}
      logic [5:0]    mask;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] mem_rd(input int k);
      return chain[k*DW +: DW];
   endfunction

   task automatic do_preload(input logic [NB*DW-1:0] val);
      preload_val = val;
      preload_en  = 1'b1;
      tick();
      preload_en  = 1'b0;
   endtask

   // full-chain load of load_data[] with byte_valid held high, observing every cycle
   task automatic run_load(input bit spurious);
      int   n;
      int   idx;
      logic acc;
      rb_q.delete();
      ld_se_cnt   = 0;
      ld_done_cyc = -1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n   = 0;
      idx = 0;
      while (n < 400 && ld_done_cyc < 0) begin
         byte_valid = 1'b1;
         byte_in    = load_data[(idx < NB) ? idx : NB-1];
         start      = spurious && (n % 7 == 3);
         acc        = byte_ready;
         tick();
         n++;
         if (acc && idx < NB) idx++;
         if (scan_enable)    ld_se_cnt++;
         if (byte_out_valid) rb_q.push_back(byte_out);
         if (done)           ld_done_cyc = n;
      end
      byte_valid = 1'b0;
      start      = 1'b0;
      $display("load: bytes_sent=%0d done_cycle=%0d scan_cycles=%0d readback_bytes=%0d",
               idx, ld_done_cyc, ld_se_cnt, rb_q.size());
   endtask

   task automatic feed_byte(input logic [DW-1:0] d);
      byte_valid = 1'b1;
      byte_in    = d;
      tick();
      byte_valid = 1'b0;
   endtask

   initial begin
      int bov_seen;
      int done_seen;
      logic [5:0] act;

      rst = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_in = '0;
      preload_en = 1'b0; preload_val = '0;

      //                start abort bv   din    busy/rdy/se/si/bov/done  mask
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'h55, 6'b000000, 6'b111111}; // byte_valid in IDLE ignored
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 6'b110000, 6'b111111}; // start -> LOAD
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 6'b110000, 6'b111111}; // wait in LOAD
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h80, 6'b101100, 6'b111111}; // accept, MSB out first
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 6'b101000, 6'b111111}; // start in SHIFT ignored
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 6'b101000, 6'b111111}; // still shifting
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 6'b000000, 6'b111011}; // abort mid-byte
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 6'b000000, 6'b111011}; // start+abort in IDLE
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 6'b110000, 6'b111011}; // start -> LOAD
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 6'b000000, 6'b111011}; // abort beats accept
      vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 6'b000000, 6'b111011}; // stays IDLE

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctrl", {26'd0, busy, byte_ready, scan_enable, scan_in, byte_out_valid, done}, 32'd0);
      chk("reset_byte_out", {24'd0, byte_out}, 32'd0);
      #4 rst = 1'b1;
      tick();

      // table-driven single-cycle vectors
      for (int i = 0; i < 11; i++) begin
         start      = vecs[i].start;
         abort      = vecs[i].abort;
         byte_valid = vecs[i].bv;
         byte_in    = vecs[i].din;
         tick();
         act = {busy, byte_ready, scan_enable, scan_in, byte_out_valid, done};
         $display("vec %0d: start=%0b abort=%0b bv=%0b din=%02h -> outs=%06b exp=%06b",
                  i, vecs[i].start, vecs[i].abort, vecs[i].bv, vecs[i].din, act, vecs[i].exp);
         chk($sformatf("vec%0d", i), {26'd0, act & vecs[i].mask}, {26'd0, vecs[i].exp & vecs[i].mask});
      end
      start = 1'b0; abort = 1'b0; byte_valid = 1'b0;

      // full load of 0x00..0x1F into an empty chain
      do_preload('0);
      for (int j = 0; j < NB; j++) load_data[j] = DW'(j);
      run_load(1'b0);
      chk("full_done_cycle", ld_done_cyc, 288);
      chk("full_scan_cycles", ld_se_cnt, 256);
      chk("full_readback_count", rb_q.size(), NB);
      tick();
      chk("full_done_single", {30'd0, done, busy}, 32'd0);
      for (int k = 0; k < NB; k++)
         chk($sformatf("full_mem%0d", k), {24'd0, mem_rd(k)}, 32'(8'h1F - k));

      // readback of preloaded image while writing all 0xFF
      for (int k = 0; k < NB; k++) preload_val[k*DW +: DW] = DW'(8'hA0 + k);
      do_preload(preload_val);
      for (int j = 0; j < NB; j++) load_data[j] = 8'hFF;
      run_load(1'b0);
      chk("rb_done_cycle", ld_done_cyc, 288);
      chk("rb_count", rb_q.size(), NB);
      for (int j = 0; j < NB && j < rb_q.size(); j++)
         chk($sformatf("rb_byte%0d", j), {24'd0, rb_q[j]}, 32'(8'hBF - j));
      for (int k = 0; k < NB; k++)
         chk($sformatf("rb_mem%0d", k), {24'd0, mem_rd(k)}, 32'hFF);
      tick();

      // handshake stall in LOAD
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c < 5; c++) begin
         byte_valid = 1'b0;
         tick();
         chk($sformatf("stall%0d", c), {29'd0, busy, byte_ready, scan_enable}, 32'b110);
      end
      feed_byte(8'h5A);
      chk("stall_accept", {29'd0, busy, byte_ready, scan_enable}, 32'b101);
      $display("stall: byte 5a accepted after 5 idle cycles");
      abort = 1'b1; tick(); abort = 1'b0;

      // abort at bit 3 of byte 2, then a clean restart with spurious starts
      start = 1'b1; tick(); start = 1'b0;
      for (int b = 0; b < 2; b++) begin
         feed_byte(DW'(8'h11 * (b + 1)));
         repeat (7) tick();
      end
      feed_byte(8'h33);
      repeat (3) tick();
      chk("abort_pre_shift", {31'd0, scan_enable}, 32'd1);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_state", {28'd0, busy, scan_enable, byte_out_valid, done}, 32'd0);
      bov_seen = 0; done_seen = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (byte_out_valid) bov_seen++;
         if (done)           done_seen++;
      end
      chk("abort_no_pulses", bov_seen + done_seen, 0);
      $display("abort: idle after abort, pulses seen=%0d", bov_seen + done_seen);
      for (int j = 0; j < NB; j++) load_data[j] = DW'(j * 7 + 3);
      run_load(1'b1);
      chk("restart_done_cycle", ld_done_cyc, 288);
      chk("restart_scan_cycles", ld_se_cnt, 256);
      for (int j = 0; j < NB; j++)
         chk($sformatf("restart_mem%0d", NB-1-j), {24'd0, mem_rd(NB-1-j)}, 32'(load_data[j]));
      tick();

      // asynchronous reset while shifting
      start = 1'b1; tick(); start = 1'b0;
      feed_byte(8'hC3);
      tick();
      chk("areset_pre", {30'd0, busy, scan_enable}, 32'b11);
      #3 rst = 1'b0;
      #1;
      chk("areset_ctrl", {26'd0, busy, byte_ready, scan_enable, scan_in, byte_out_valid, done}, 32'd0);
      chk("areset_byte_out", {24'd0, byte_out}, 32'd0);
      $display("areset: outputs cleared without a clock edge");
      tick();
      #3 rst = 1'b1;
      tick();
      chk("areset_release", {29'd0, busy, byte_ready, scan_enable}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // absolute watchdog so the bench can never hang
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
